// File: rtl/dcim_result_tx.sv
// Buffers 32-bit DCIM result words in a small FIFO and sends each word to the
// host LSB first as four bytes over a 4-phase strobe/ack handshake.
module dcim_result_tx #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  input  logic                     host_ack,
  output logic [7:0]               tx_data,
  output logic                     tx_strobe,
  output logic                     tx_last,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

  state_t          state_q;
  logic [31:0]     mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      byte_idx_q;
  logic            ack_meta_q, ack_s_q;
  logic [7:0]      tx_data_q;
  logic            tx_strobe_q, tx_last_q;
  logic            push, pop;
  logic [31:0]     head;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  assign head       = mem_q[rd_ptr_q];
  assign in_ready   = ena && !flush && (count_q < DEPTH_C);
  assign push       = in_valid && in_ready;
  // The head word leaves only once its last byte has been fully released.
  assign pop        = ena && !flush && (state_q == RELEASE) && !ack_s_q && (byte_idx_q == 2'd3);
  assign fifo_count = count_q;
  assign tx_data    = tx_data_q;
  assign tx_strobe  = tx_strobe_q;
  assign tx_last    = tx_last_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= host_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_idx_q  <= 2'd0;
      tx_data_q   <= 8'h00;
      tx_strobe_q <= 1'b0;
      tx_last_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      byte_idx_q  <= 2'd0;
      tx_strobe_q <= 1'b0;
      tx_last_q   <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          // A stale ack left over from a flush must fall before a new byte starts.
          if (count_q != '0 && !ack_s_q) begin
            byte_idx_q <= 2'd0;
            tx_data_q  <= byte_sel(head, 2'd0);
            tx_last_q  <= 1'b0;
            state_q    <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack_s_q) begin
            tx_strobe_q <= 1'b0;
            state_q     <= RELEASE;
          end else begin
            tx_strobe_q <= 1'b1;
          end
        end
        RELEASE: begin
          tx_strobe_q <= 1'b0;
          if (!ack_s_q) begin
            if (byte_idx_q == 2'd3) begin
              state_q <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              tx_data_q  <= byte_sel(head, byte_idx_q + 2'd1);
              tx_last_q  <= (byte_idx_q == 2'd2);
              state_q    <= PRESENT;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
